// File: rtl/alu_ctrl_muldiv.sv
// MIPS ALU control decode plus HI/LO registers and an iterative multiply/divide engine.
// Define ALU_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module alu_ctrl_muldiv #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [5:0]       Opcode,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       ALUControl,
  output logic             shift_var,
  output logic             hilo_wb,
  output logic [WIDTH-1:0] hilo_rd_data,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam logic [5:0] F_ADD  = 6'b100000, F_SUB  = 6'b100010, F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101, F_XOR  = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;
  localparam logic [5:0] O_SLTI = 6'b001010, O_SLTIU = 6'b001011, O_ANDI = 6'b001100;
  localparam logic [5:0] O_ORI  = 6'b001101, O_XORI  = 6'b001110, O_LUI  = 6'b001111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  always_comb begin
    ALUControl = 4'b0000;
    shift_var  = 1'b0;
    hilo_wb    = 1'b0;
    case (ALUOp)
      2'b00: ALUControl = 4'b0010;
      2'b01: ALUControl = 4'b0110;
      2'b10: begin
        case (Funct)
          F_ADD:  ALUControl = 4'b0010;
          F_SUB:  ALUControl = 4'b0110;
          F_AND:  ALUControl = 4'b0000;
          F_OR:   ALUControl = 4'b0001;
          F_XOR:  ALUControl = 4'b0100;
          F_NOR:  ALUControl = 4'b1100;
          F_SLT:  ALUControl = 4'b0111;
          F_SLTU: ALUControl = 4'b1001;
          F_SLL:  ALUControl = 4'b1110;
          F_SRL:  ALUControl = 4'b1111;
          F_SRA:  ALUControl = 4'b1011;
          F_SLLV: begin ALUControl = 4'b1110; shift_var = 1'b1; end
          F_SRLV: begin ALUControl = 4'b1111; shift_var = 1'b1; end
          F_SRAV: begin ALUControl = 4'b1011; shift_var = 1'b1; end
          F_MFHI, F_MFLO: hilo_wb = 1'b1;
          default: ;
        endcase
      end
      default: begin
        case (Opcode)
          O_ANDI:  ALUControl = 4'b0000;
          O_ORI:   ALUControl = 4'b0001;
          O_XORI:  ALUControl = 4'b0100;
          O_SLTI:  ALUControl = 4'b0111;
          O_SLTIU: ALUControl = 4'b1001;
          O_LUI:   ALUControl = 4'b1010;
          default: ;
        endcase
      end
    endcase
  end

  assign hilo_rd_data = !hilo_wb ? '0 : (Funct == F_MFHI) ? hi_q : lo_q;

  // Funct 0110xx covers MULT/MULTU/DIV/DIVU; bit 1 selects divide, bit 0 unsigned.
  logic             md_op, op_div, op_signed, sa, sb, mt_hi, mt_lo;
  logic [WIDTH-1:0] ma, mb;

  assign md_op     = instr_valid && (ALUOp == 2'b10) && (Funct[5:2] == 4'b0110);
  assign op_div    = Funct[1];
  assign op_signed = ~Funct[0];
  assign sa        = op_signed & rs_val[WIDTH-1];
  assign sb        = op_signed & rt_val[WIDTH-1];
  assign ma        = sa ? -rs_val : rs_val;
  assign mb        = sb ? -rt_val : rt_val;
  assign mt_hi     = instr_valid && (ALUOp == 2'b10) && (Funct == F_MTHI) && (state_q == S_IDLE);
  assign mt_lo     = instr_valid && (ALUOp == 2'b10) && (Funct == F_MTLO) && (state_q == S_IDLE);

  // {p_q upper, p_q lower} is {accumulator, multiplier} or {remainder, dividend/quotient}.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step_nx, prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    mul_nx   = {mul_sum, p_q[WIDTH-1:1]};
    div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    div_nx   = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    step_nx  = div_q ? div_nx : mul_nx;
    prod     = neg_q ? -step_nx : step_nx;
    // A zero divisor leaves |rs| as the remainder, so re-signing it restores rs exactly.
    quo      = dz_q ? '1 : (neg_q ? -step_nx[WIDTH-1:0] : step_nx[WIDTH-1:0]);
    rem      = rneg_q ? -step_nx[2*WIDTH-1:WIDTH] : step_nx[2*WIDTH-1:WIDTH];
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
  assign fast_prod = (sa ^ sb) ? -fast_mag : fast_mag;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_op) begin
          stall   = 1'b1;
          p_d     = {{WIDTH{1'b0}}, ma};
          m_d     = mb;
          div_d   = op_div;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          dz_d    = (rt_val == '0);
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
`ifdef ALU_FAST_MUL_EN
          if (!op_div) begin
            {hi_d, lo_d} = fast_prod;
            state_d      = S_DONE;
          end
`endif
        end else if (mt_hi) begin
          hi_d = rs_val;
        end else if (mt_lo) begin
          lo_d = rs_val;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        p_d   = step_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      // DONE ignores md_op so the still-held instruction cannot restart.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    p_q    <= p_d;
    m_q    <= m_d;
    div_q  <= div_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
    dz_q   <= dz_d;
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode table, multiply/divide sequences, reset abort, MTHI/MTLO.
module tb_alu_ctrl_muldiv;
  logic        clk, rst, instr_valid;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct, Opcode;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  ALUControl;
  logic        shift_var, hilo_wb, stall;
  logic [31:0] hilo_rd_data, hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef ALU_FAST_MUL_EN
  localparam int MUL_ST = 1;
`else
  localparam int MUL_ST = 33;
`endif
  localparam int DIV_ST = 33;

  alu_ctrl_muldiv #(.WIDTH(32), .HILO_RST(32'h0)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .ALUOp(ALUOp), .Funct(Funct),
    .Opcode(Opcode), .rs_val(rs_val), .rt_val(rt_val), .ALUControl(ALUControl),
    .shift_var(shift_var), .hilo_wb(hilo_wb), .hilo_rd_data(hilo_rd_data),
    .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [5:0] oc;
    logic [3:0] ctl;
    logic       sv;
    logic       wb;
  } dvec_t;

  dvec_t tbl[25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one mul/div, hold it until the DONE cycle, then release it.
  task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_st,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = 0;
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = f; rs_val = a; rt_val = b;
    #1;
    while (stall && n < 200) begin
      n++;
      step();
    end
    chk({nm, "_stall_cycles"}, 64'(n), 64'(exp_st));
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    instr_valid = 1'b0;
    step();
    chk({nm, "_no_restart"}, 64'(stall), 64'(0));
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; ALUOp = 2'b00; Funct = 6'h0; Opcode = 6'h0;
    rs_val = 32'h0; rt_val = 32'h0;

    tbl[0]  = '{2'b00, 6'b000000, 6'b000000, 4'b0010, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 6'b000000, 6'b000000, 4'b0110, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 6'b100110, 6'b000000, 4'b0100, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 6'b100000, 6'b000000, 4'b0010, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 6'b100010, 6'b000000, 4'b0110, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 6'b100100, 6'b000000, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{2'b10, 6'b100101, 6'b000000, 4'b0001, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 6'b100111, 6'b000000, 4'b1100, 1'b0, 1'b0};
    tbl[8]  = '{2'b10, 6'b101010, 6'b000000, 4'b0111, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 6'b101011, 6'b000000, 4'b1001, 1'b0, 1'b0};
    tbl[10] = '{2'b10, 6'b000000, 6'b000000, 4'b1110, 1'b0, 1'b0};
    tbl[11] = '{2'b10, 6'b000100, 6'b000000, 4'b1110, 1'b1, 1'b0};
    tbl[12] = '{2'b10, 6'b000010, 6'b000000, 4'b1111, 1'b0, 1'b0};
    tbl[13] = '{2'b10, 6'b000110, 6'b000000, 4'b1111, 1'b1, 1'b0};
    tbl[14] = '{2'b10, 6'b000011, 6'b000000, 4'b1011, 1'b0, 1'b0};
    tbl[15] = '{2'b10, 6'b000111, 6'b000000, 4'b1011, 1'b1, 1'b0};
    tbl[16] = '{2'b10, 6'b010000, 6'b000000, 4'b0000, 1'b0, 1'b1};
    tbl[17] = '{2'b10, 6'b010010, 6'b000000, 4'b0000, 1'b0, 1'b1};
    tbl[18] = '{2'b10, 6'b111111, 6'b000000, 4'b0000, 1'b0, 1'b0};
    tbl[19] = '{2'b11, 6'b000000, 6'b001011, 4'b1001, 1'b0, 1'b0};
    tbl[20] = '{2'b11, 6'b000000, 6'b001111, 4'b1010, 1'b0, 1'b0};
    tbl[21] = '{2'b11, 6'b000000, 6'b001101, 4'b0001, 1'b0, 1'b0};
    tbl[22] = '{2'b11, 6'b000000, 6'b001110, 4'b0100, 1'b0, 1'b0};
    tbl[23] = '{2'b11, 6'b000000, 6'b001010, 4'b0111, 1'b0, 1'b0};
    tbl[24] = '{2'b11, 6'b000000, 6'b111111, 4'b0000, 1'b0, 1'b0};

    repeat (2) step();
    chk("reset_stall", 64'(stall), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 25; i++) begin
      instr_valid = 1'b1; ALUOp = tbl[i].op; Funct = tbl[i].fn; Opcode = tbl[i].oc;
      #1;
      chk($sformatf("dec%0d_ctl", i), 64'(ALUControl), 64'(tbl[i].ctl));
      chk($sformatf("dec%0d_sv", i), 64'(shift_var), 64'(tbl[i].sv));
      chk($sformatf("dec%0d_wb", i), 64'(hilo_wb), 64'(tbl[i].wb));
      chk($sformatf("dec%0d_stall", i), 64'(stall), 64'(0));
      chk($sformatf("dec%0d_rd", i), 64'(hilo_rd_data), 64'(0));
    end
    instr_valid = 1'b0; Opcode = 6'h0;
    step();

    // A mul/div opcode without instr_valid must not start the engine.
    ALUOp = 2'b10; Funct = 6'b011000; rs_val = 32'd3; rt_val = 32'd4;
    #1;
    chk("invalid_md_stall", 64'(stall), 64'(0));
    step();

    run_md("multu", 6'b011001, 32'hFFFFFFFF, 32'h2, MUL_ST, 32'h1, 32'hFFFFFFFE);
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b010000;
    #1;
    chk("mfhi_wb", 64'(hilo_wb), 64'(1));
    chk("mfhi_data", 64'(hilo_rd_data), 64'(32'h1));
    Funct = 6'b010010;
    #1;
    chk("mflo_data", 64'(hilo_rd_data), 64'(32'hFFFFFFFE));
    instr_valid = 1'b0;
    step();

    run_md("mult_neg", 6'b011000, 32'hFFFFFFFD, 32'd7, MUL_ST, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("mult_2neg", 6'b011000, 32'hFFFFFFFD, 32'hFFFFFFFB, MUL_ST, 32'h0, 32'd15);
    run_md("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2, DIV_ST, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negdvsr", 6'b011010, 32'd7, 32'hFFFFFFFE, DIV_ST, 32'h1, 32'hFFFFFFFD);
    run_md("divu_zero", 6'b011011, 32'd5, 32'd0, DIV_ST, 32'd5, 32'hFFFFFFFF);
    run_md("div_zero_neg", 6'b011010, 32'hFFFFFFF9, 32'd0, DIV_ST, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_md("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, DIV_ST, 32'h0, 32'h80000000);

    // Reset on the 10th RUN cycle aborts the divide.
    instr_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b011011; rs_val = 32'd100; rt_val = 32'd7;
    repeat (10) step();
    chk("abort_running", 64'(stall), 64'(1));
    rst = 1'b1; instr_valid = 1'b0;
    step();
    chk("abort_stall", 64'(stall), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    step();
    run_md("divu_reissue", 6'b011011, 32'd100, 32'd7, DIV_ST, 32'd2, 32'd14);

    instr_valid = 1'b1; ALUOp = 2'b10; Funct = 6'b010001; rs_val = 32'hA5A5A5A5;
    #1;
    chk("mthi_stall", 64'(stall), 64'(0));
    step();
    chk("mthi_hi", 64'(hi), 64'(32'hA5A5A5A5));
    Funct = 6'b010011; rs_val = 32'h5A5A5A5A;
    step();
    chk("mtlo_lo", 64'(lo), 64'(32'h5A5A5A5A));
    chk("mtlo_hi_kept", 64'(hi), 64'(32'hA5A5A5A5));
    instr_valid = 1'b0;
    step();

    run_md("mult_held", 6'b011000, 32'd6, 32'd7, MUL_ST, 32'h0, 32'd42);
    repeat (3) step();
    chk("held_idle", 64'(stall), 64'(0));
    chk("held_lo_stable", 64'(lo), 64'(32'd42));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
